// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / UART sequencer: FSM state encodings,
// EXEC stage length and the op-codes understood by the companion ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_B    = 3'd1,
    GET_OP   = 3'd2,
    EXEC     = 3'd3,
    SEND_RES = 3'd4,
    WAIT_RES = 3'd5,
    SEND_FLG = 3'd6,
    WAIT_FLG = 3'd7
  } state_t;

  // One cycle for the ALU to register its result, one cycle of margin.
  localparam int unsigned EXEC_CYCLES = 32'd2;
  localparam int unsigned EXEC_CNT_W  = 32'd2;

  // ALU op-codes (forwarded unchecked by the sequencer).
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;

endpackage

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and an op-code from a UART receiver, gives
// the ALU time to compute, then sends the result byte followed by a flags
// byte {6'b0, overflow, zero} through a UART transmitter.
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned NSel = 6
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_done,
  input  logic            i_tx_done,
  input  logic [N-1:0]    i_alu_result,
  input  logic            i_alu_overflow,
  input  logic            i_alu_zero,
  output logic [N-1:0]    o_alu_A,
  output logic [N-1:0]    o_alu_B,
  output logic [NSel-1:0] o_alu_Op,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_start,
  output logic            o_busy
);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [EXEC_CNT_W-1:0]   exec_cnt_r;
  logic                    exec_last_s;
  logic [N-1:0]            alu_a_r;
  logic [N-1:0]            alu_b_r;
  logic [NSel-1:0]         alu_op_r;
  logic [7:0]              tx_data_r;
  logic                    tx_start_r;
  logic                    busy_r;
  logic                    ovf_r;
  logic                    zero_r;
  logic                    unused_rx_bits_s;

  // Upper rx bits beyond N / NSel are intentionally discarded.
  assign unused_rx_bits_s = ^i_rx_data;

  assign exec_last_s = (exec_cnt_r == EXEC_CNT_W'(EXEC_CYCLES - 32'd1));

  // Next-state logic: receive three bytes, wait in EXEC, send two bytes.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_rx_done) state_next_s = GET_B;
        else           state_next_s = IDLE;
      end
      GET_B: begin
        if (i_rx_done) state_next_s = GET_OP;
        else           state_next_s = GET_B;
      end
      GET_OP: begin
        if (i_rx_done) state_next_s = EXEC;
        else           state_next_s = GET_OP;
      end
      EXEC: begin
        if (exec_last_s) state_next_s = SEND_RES;
        else             state_next_s = EXEC;
      end
      SEND_RES: state_next_s = WAIT_RES;
      WAIT_RES: begin
        if (i_tx_done) state_next_s = SEND_FLG;
        else           state_next_s = WAIT_RES;
      end
      SEND_FLG: state_next_s = WAIT_FLG;
      WAIT_FLG: begin
        if (i_tx_done) state_next_s = IDLE;
        else           state_next_s = WAIT_FLG;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register; reset aborts any transaction immediately.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // Datapath: operand/op capture, exec counter, tx byte and start pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_op_r   <= '0;
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      exec_cnt_r <= '0;
      ovf_r      <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      busy_r     <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (i_rx_done) alu_a_r <= i_rx_data[N-1:0];
        end
        GET_B: begin
          if (i_rx_done) alu_b_r <= i_rx_data[N-1:0];
        end
        GET_OP: begin
          if (i_rx_done) begin
            alu_op_r   <= i_rx_data[NSel-1:0];
            exec_cnt_r <= '0;
          end
        end
        EXEC: begin
          if (!exec_last_s) exec_cnt_r <= exec_cnt_r + EXEC_CNT_W'(1);
        end
        SEND_RES: begin
          tx_data_r  <= 8'(i_alu_result);
          tx_start_r <= 1'b1;
          ovf_r      <= i_alu_overflow;
          zero_r     <= i_alu_zero;
        end
        SEND_FLG: begin
          tx_data_r  <= {6'b000000, ovf_r, zero_r};
          tx_start_r <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_alu_A    = alu_a_r;
  assign o_alu_B    = alu_b_r;
  assign o_alu_Op   = alu_op_r;
  assign o_tx_data  = tx_data_r;
  assign o_tx_start = tx_start_r;
  assign o_busy     = busy_r;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a small registered ALU model
// (ADD/SUB/AND/OR, or a fixed stub result) and hand-driven UART pulses.
module tb_alu_uart_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       alu_zero;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       use_stub;
  logic [8:0] alu_calc;

  int checks = 0;
  int errors = 0;

  alu_uart_sequencer #(.N(8), .NSel(6)) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_rx_data     (rx_data),
    .i_rx_done     (rx_done),
    .i_tx_done     (tx_done),
    .i_alu_result  (alu_result),
    .i_alu_overflow(alu_overflow),
    .i_alu_zero    (alu_zero),
    .o_alu_A       (alu_a),
    .o_alu_B       (alu_b),
    .o_alu_Op      (alu_op),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .o_busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU model: carry/borrow in bit 8.
  always_comb begin
    case (alu_op)
      6'h20:   alu_calc = {1'b0, alu_a} + {1'b0, alu_b};
      6'h22:   alu_calc = {1'b0, alu_a} - {1'b0, alu_b};
      6'h24:   alu_calc = {1'b0, alu_a & alu_b};
      6'h25:   alu_calc = {1'b0, alu_a | alu_b};
      default: alu_calc = 9'h000;
    endcase
  end

  // Registered ALU (or stub returning 0xAA with overflow set).
  always @(posedge clock) begin
    if (use_stub) begin
      alu_result   <= 8'hAA;
      alu_overflow <= 1'b1;
      alu_zero     <= 1'b0;
    end else begin
      alu_result   <= alu_calc[7:0];
      alu_overflow <= alu_calc[8];
      alu_zero     <= (alu_calc[7:0] == 8'h00);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
  endtask

  // Returns the number of negedges until o_tx_start is seen, -1 if none in 20.
  task automatic wait_start(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: A=%h B=%h Op=%h tx=%h start=%b busy=%b, required all 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy);
    end
  endtask

  task automatic test_basic_add();
    int cyc;
    use_stub = 1'b0;
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
      errors++;
      $display("FAIL add_operands: A=%h B=%h Op=%h, required 05 03 20", alu_a, alu_b, alu_op);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL add_busy: got %b, required 1", busy);
    end
    wait_start(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL add_latency: start after %0d cycles, required 3", cyc);
    end
    checks++;
    if (tx_data !== 8'h08) begin
      errors++;
      $display("FAIL add_result: tx=%h, required 08", tx_data);
    end
    pulse_tx_done();
    wait_start(cyc);
    checks++;
    if (cyc !== 1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL add_flags: cycles=%0d tx=%h, required 1 and 00", cyc, tx_data);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL add_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_stub_sequence();
    int cyc;
    use_stub = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    wait_start(cyc);
    checks++;
    if (cyc !== 3 || tx_data !== 8'hAA) begin
      errors++;
      $display("FAIL stub_result: cycles=%0d tx=%h, required 3 and AA", cyc, tx_data);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hAA) begin
        errors++;
        $display("FAIL stub_hold: start=%b busy=%b tx=%h, required 0 1 AA", tx_start, busy, tx_data);
      end
    end
    pulse_tx_done();
    wait_start(cyc);
    checks++;
    if (cyc !== 1 || tx_data !== 8'h02) begin
      errors++;
      $display("FAIL stub_flags: cycles=%0d tx=%h, required 1 and 02", cyc, tx_data);
    end
    @(negedge clock);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL stub_pulse_width: start=%b, required 0", tx_start);
    end
    pulse_tx_done();
    use_stub = 1'b0;
  endtask

  task automatic test_rx_ignored();
    int cyc;
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h20);
    wait_start(cyc);
    checks++;
    if (cyc !== 3 || tx_data !== 8'h30) begin
      errors++;
      $display("FAIL ign_result: cycles=%0d tx=%h, required 3 and 30", cyc, tx_data);
    end
    send_byte(8'hFF);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h10, 8'h20, 6'h20}) begin
      errors++;
      $display("FAIL ign_operands: A=%h B=%h Op=%h, required 10 20 20", alu_a, alu_b, alu_op);
    end
    pulse_tx_done();
    wait_start(cyc);
    checks++;
    if (cyc !== 1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL ign_flags: cycles=%0d tx=%h, required 1 and 00", cyc, tx_data);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0 || alu_a !== 8'h10) begin
      errors++;
      $display("FAIL ign_idle: busy=%b A=%h, required 0 and 10", busy, alu_a);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    wait_start(cyc);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: A=%h B=%h Op=%h tx=%h start=%b busy=%b, required all 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy);
    end
    pulse_tx_done();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (tx_start !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_txdone: start=%b busy=%b, required 0 0", tx_start, busy);
      end
    end
  endtask

  task automatic test_op_trunc();
    int cyc;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hE4);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h12, 8'h34, 6'h24}) begin
      errors++;
      $display("FAIL trunc_operands: A=%h B=%h Op=%h, required 12 34 24", alu_a, alu_b, alu_op);
    end
    wait_start(cyc);
    checks++;
    if (cyc !== 3 || tx_data !== 8'h10) begin
      errors++;
      $display("FAIL trunc_result: cycles=%0d tx=%h, required 3 and 10", cyc, tx_data);
    end
    pulse_tx_done();
    wait_start(cyc);
    pulse_tx_done();
  endtask

  task automatic test_back_to_back();
    int cyc;
    // First transaction: FF + 01 -> 00 with carry and zero.
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h20);
    pulse_tx_done();
    wait_start(cyc);
    checks++;
    if (cyc !== 2 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL b2b_byte0: cycles=%0d tx=%h, required 2 and 00", cyc, tx_data);
    end
    pulse_tx_done();
    wait_start(cyc);
    checks++;
    if (cyc !== 1 || tx_data !== 8'h03) begin
      errors++;
      $display("FAIL b2b_byte1: cycles=%0d tx=%h, required 1 and 03", cyc, tx_data);
    end
    send_byte(8'h07);
    checks++;
    if (alu_a !== 8'hFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_early_load: A=%h busy=%b, required FF and 1", alu_a, busy);
    end
    pulse_tx_done();
    // Second transaction: 07 - 02 -> 05.
    send_byte(8'h07);
    checks++;
    if (alu_a !== 8'h07) begin
      errors++;
      $display("FAIL b2b_second_load: A=%h, required 07", alu_a);
    end
    send_byte(8'h02);
    send_byte(8'h22);
    wait_start(cyc);
    checks++;
    if (cyc !== 3 || tx_data !== 8'h05) begin
      errors++;
      $display("FAIL b2b_byte2: cycles=%0d tx=%h, required 3 and 05", cyc, tx_data);
    end
    pulse_tx_done();
    wait_start(cyc);
    checks++;
    if (cyc !== 1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL b2b_byte3: cycles=%0d tx=%h, required 1 and 00", cyc, tx_data);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    tx_done  = 1'b0;
    use_stub = 1'b0;
    test_reset();
    test_basic_add();
    test_stub_sequence();
    test_rx_ignored();
    test_reset_mid();
    test_op_trunc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
ALU_UART_SEQUENCER -- requirements
Module: alu_uart_sequencer

Interface
REQ-001 Parameter N, default 8: ALU operand/result width; SHALL satisfy 1 <= N <= 8.
REQ-002 Parameter NSel, default 6: ALU op-code width; SHALL satisfy 1 <= NSel <= 8.
REQ-003 i_clock  in  1  system clock; all state changes on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_rx_data  in  8  byte from UART receiver; valid only while i_rx_done=1.
REQ-006 i_rx_done  in  1  one-cycle pulse marking a received byte.
REQ-007 i_tx_done  in  1  one-cycle pulse: UART transmitter finished current byte.
REQ-008 i_alu_result  in  N  registered ALU result.
REQ-009 i_alu_overflow, i_alu_zero  in  1 each  registered ALU flags.
REQ-010 o_alu_A, o_alu_B  out  N each  registered ALU operands.
REQ-011 o_alu_Op  out  NSel  registered ALU op-code.
REQ-012 o_tx_data  out  8  byte to UART transmitter.
REQ-013 o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-014 o_busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be: IDLE, GET_B, GET_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-016 IDLE: on i_rx_done, o_alu_A <= i_rx_data[N-1:0]; go GET_B.
REQ-017 GET_B: on i_rx_done, o_alu_B <= i_rx_data[N-1:0]; go GET_OP.
REQ-018 GET_OP: on i_rx_done, o_alu_Op <= i_rx_data[NSel-1:0]; go EXEC; clear exec counter.
REQ-019 EXEC SHALL last exactly 2 cycles (one for the ALU to register, one margin), then go SEND_RES.
REQ-020 SEND_RES (1 cycle): o_tx_data <= zero-extended i_alu_result, o_tx_start=1, latch flags; go WAIT_RES.
REQ-021 WAIT_RES: hold o_tx_data; on i_tx_done go SEND_FLG.
REQ-022 SEND_FLG (1 cycle): o_tx_data <= {6'b0, overflow, zero} (latched in SEND_RES), o_tx_start=1; go WAIT_FLG.
REQ-023 WAIT_FLG: on i_tx_done go IDLE.
REQ-024 i_rx_done in EXEC, SEND_*, WAIT_* SHALL be ignored; no operand/op change.
REQ-025 i_tx_done outside WAIT_RES/WAIT_FLG SHALL be ignored.
REQ-026 o_alu_A/B/Op SHALL hold their values from load until the next load or reset, including through IDLE.
REQ-027 o_tx_start SHALL never be high for two consecutive cycles.
REQ-028 i_rx_data bits above N (operands) or NSel (op) SHALL be discarded.
REQ-029 Op-code is forwarded unchecked; invalid codes are the ALU's concern.

Reset
REQ-030 While i_reset=1 at an edge: state <= IDLE; o_alu_A, o_alu_B, o_alu_Op, o_tx_data <= 0; o_tx_start <= 0; o_busy <= 0; exec counter and latched flags <= 0.
REQ-031 Reset SHALL take priority over i_rx_done/i_tx_done in the same cycle and SHALL abort any state, including mid-transmission.

Structure
REQ-032 Shared package alu_pkg SHALL hold state encodings, EXEC_CYCLES=2, and ALU op-code constants.
REQ-033 No sub-module; block is a single FSM with datapath registers, instantiated beside the ALU at top level.

Verification (N=8, NSel=6, bench UART stubs)
REQ-034 rx 0x05, 0x03, 0x20 with real ALU -> o_alu_A=0x05, B=0x03, Op=0x20; first o_tx_start 3 cycles after Op load with o_tx_data=0x08.
REQ-035 Stub ALU result 0xAA, overflow=1, zero=0 -> tx bytes 0xAA then 0x02, each start pulse one cycle wide; second start only after i_tx_done.
REQ-036 rx byte 0xFF during WAIT_RES -> operands unchanged, sequence completes, returns IDLE, o_busy=0.
REQ-037 i_reset asserted in WAIT_RES -> next cycle state IDLE, all outputs 0; a subsequent i_tx_done produces no start pulse.
REQ-038 rx 0x12, 0x34, 0xE4 -> o_alu_Op=0x24 (bits 7:6 dropped).
REQ-039 Two back-to-back full transactions -> second A loaded only after WAIT_FLG exit; four tx bytes in order.
